// File: rtl/qlm_share_arb_if.sv
// Requester and response channels between datapath clients and the shared
// QLM_w4q3 multiplier pipeline.
interface qlm_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_x;
  logic [NREQ*16-1:0] req_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_p;
  logic               busy;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/qlm_share_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared QLM_w4q3
// approximate multiplier; responses return in grant order tagged with the id.
module qlm_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic             clk,
  input logic             rst_n,
  qlm_share_arb_if.slave  bus
);
  logic            s1_v;
  logic [15:0]     s1_x;
  logic [15:0]     s1_y;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  rr_ptr;
  logic            s2_adv;
  logic            s1_adv;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  next_ptr;
  logic [31:0]     mult_p;

  assign s2_adv = !bus.rsp_valid | bus.rsp_ready;
  assign s1_adv = !s1_v | s2_adv;

  // Search upward from rr_ptr, wrapping; first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (s1_adv && !grant_any && bus.req_valid[idx]) begin
        grant_any  = 1'b1;
        grant_id   = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign next_ptr      = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
  assign bus.req_ready = rst_n ? grant : '0;
  assign bus.busy      = s1_v | bus.rsp_valid;

  QLM_w4q3 u_mult (
    .x (s1_x),
    .y (s1_y),
    .p (mult_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s1_x          <= '0;
      s1_y          <= '0;
      s1_id         <= '0;
      rr_ptr        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_p     <= '0;
      bus.rsp_id    <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= grant_any;
        if (grant_any) begin
          s1_x   <= bus.req_x[grant_id*16 +: 16];
          s1_y   <= bus.req_y[grant_id*16 +: 16];
          s1_id  <= grant_id;
          rr_ptr <= next_ptr;
        end
      end
      // Payload holds across bubbles so a stalled or idle output never changes.
      if (s2_adv) begin
        bus.rsp_valid <= s1_v;
        if (s1_v) begin
          bus.rsp_p  <= mult_p;
          bus.rsp_id <= s1_id;
        end
      end
    end
  end
endmodule

// Mitchell-style log multiplier: 4 fraction bits kept below each leading one,
// product mantissa quantised to 3 fraction bits before the final shift.
module QLM_w4q3 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);
  logic [3:0]  kx, ky;
  logic [3:0]  fx, fy;
  logic [4:0]  s;
  logic [5:0]  e;
  logic [3:0]  mant;
  logic [34:0] prod;

  always_comb begin
    kx = '0;
    ky = '0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) kx = 4'(i);
      if (y[i]) ky = 4'(i);
    end
    fx   = 4'({x, 4'b0000} >> kx);
    fy   = 4'({y, 4'b0000} >> ky);
    s    = {1'b0, fx} + {1'b0, fy};
    e    = {2'b00, kx} + {2'b00, ky} + {5'b00000, s[4]};
    mant = 4'({1'b1, s[3:0]} >> 1);
    prod = 35'(mant) << e;
    p    = (x == '0 || y == '0) ? '0 : 32'(prod >> 3);
  end
endmodule

// File: tb/tb_qlm_share_arb.sv
// Directed and random checks of qlm_share_arb against an independent
// QLM_w4q3 arithmetic model, with an in-order response scoreboard.
module tb_qlm_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   rspCount;
  logic [33:0] sbQueue[$];
  logic        holdPrev;
  logic [31:0] prevP;
  logic [IDW-1:0] prevId;

  qlm_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  qlm_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] qlmModel(input logic [15:0] x, input logic [15:0] y);
    int kx, ky, fx, fy, s, e;
    longint v;
    if (x == 16'd0 || y == 16'd0) return 32'd0;
    kx = 15;
    while (x[kx] == 1'b0) kx--;
    ky = 15;
    while (y[ky] == 1'b0) ky--;
    fx = (kx >= 4) ? ((int'(x) >> (kx - 4)) & 15) : ((int'(x) << (4 - kx)) & 15);
    fy = (ky >= 4) ? ((int'(y) >> (ky - 4)) & 15) : ((int'(y) << (4 - ky)) & 15);
    s = fx + fy;
    e = kx + ky;
    if (s >= 16) begin
      s = s - 16;
      e = e + 1;
    end
    v = longint'(8 + (s >> 1));
    if (e >= 3) v = v << (e - 3);
    else        v = v >> (3 - e);
    return v[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
    bus.req_valid = valid;
    bus.rsp_ready = ready;
  endtask

  task automatic setOperand(input int i, input logic [15:0] x, input logic [15:0] y);
    bus.req_x[i*16 +: 16] = x;
    bus.req_y[i*16 +: 16] = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus('0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((sbQueue.size() != 0 || bus.busy) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_queue_empty"}, sbQueue.size(), 0);
    checkOutput({tag, "_idle"}, {31'd0, bus.busy}, 0);
    tick();
  endtask

  // Scoreboard: push on handshake, pop on response, enforce hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbQueue.delete();
      holdPrev = 1'b0;
    end else begin
      logic [33:0] ent;
      checkOutput("ready_onehot0", {31'd0, $onehot0(bus.req_ready)}, 1);
      if (holdPrev) begin
        checkOutput("stall_valid", {31'd0, bus.rsp_valid}, 1);
        checkOutput("stall_p", bus.rsp_p, prevP);
        checkOutput("stall_id", {30'd0, bus.rsp_id}, {30'd0, prevId});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checkOutput("sb_nonempty", {31'd0, sbQueue.size() != 0}, 1);
        if (sbQueue.size() != 0) begin
          ent = sbQueue.pop_front();
          checkOutput("rsp_id", {30'd0, bus.rsp_id}, {30'd0, ent[33:32]});
          checkOutput("rsp_p", bus.rsp_p, ent[31:0]);
          rspCount++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sbQueue.push_back({2'(i), qlmModel(bus.req_x[i*16 +: 16], bus.req_y[i*16 +: 16])});
      end
      holdPrev = bus.rsp_valid && !bus.rsp_ready;
      prevP    = bus.rsp_p;
      prevId   = bus.rsp_id;
    end
  end

  initial begin
    int accepts;
    int base;
    logic [3:0] ptrSeq [3];
    checks   = 0;
    failures = 0;
    rspCount = 0;
    holdPrev = 1'b0;
    rst_n    = 1'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    applyStimulus('1, 1'b1);

    // Reset values with every requester asking.
    @(negedge clk);
    checkOutput("reset_ready", {28'd0, bus.req_ready}, 0);
    checkOutput("reset_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    checkOutput("reset_rsp_p", bus.rsp_p, 0);
    checkOutput("reset_rsp_id", {30'd0, bus.rsp_id}, 0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 0);
    tick();
    applyStimulus('0, 1'b1);
    rst_n = 1'b1;

    // Single request from requester 2.
    setOperand(2, 16'h0040, 16'h0020);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("single_ready", {28'd0, bus.req_ready}, 32'h4);
    checkOutput("single_busy_pre", {31'd0, bus.busy}, 0);
    tick();
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("single_lat_s1", {31'd0, bus.rsp_valid}, 0);
    checkOutput("single_busy_s1", {31'd0, bus.busy}, 1);
    tick();
    @(negedge clk);
    checkOutput("single_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    checkOutput("single_rsp_id", {30'd0, bus.rsp_id}, 2);
    checkOutput("single_rsp_p", bus.rsp_p, qlmModel(16'h0040, 16'h0020));
    checkOutput("single_rsp_p_exact", bus.rsp_p, 32'h0000_0800);
    tick();
    @(negedge clk);
    checkOutput("single_rsp_drained", {31'd0, bus.rsp_valid}, 0);
    checkOutput("single_busy_post", {31'd0, bus.busy}, 0);
    tick();

    // Round-robin fairness from reset.
    applyReset();
    for (int i = 0; i < NREQ; i++) setOperand(i, 16'(16'h1111 * (i + 1)), 16'h0101);
    base = rspCount;
    applyStimulus(4'hF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_grant_%0d", k), {28'd0, bus.req_ready}, 32'(1 << (k % 4)));
      tick();
    end
    applyStimulus('0, 1'b1);
    waitDrain("rr");
    checkOutput("rr_responses", rspCount - base, 8);

    // Backpressure: two entries fill the pipe, then the grant stops.
    accepts = 0;
    applyStimulus(4'b0010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      setOperand(1, 16'(16'h0100 + k * 16'h0123), 16'(16'h0003 + k));
      @(negedge clk);
      if (bus.req_ready[1]) accepts++;
      if (k >= 2) checkOutput($sformatf("bp_stall_%0d", k), {28'd0, bus.req_ready}, 0);
      tick();
    end
    checkOutput("bp_accepts", accepts, 2);
    base = rspCount;
    applyStimulus('0, 1'b1);
    waitDrain("bp");
    checkOutput("bp_responses", rspCount - base, 2);

    // Pointer now sits at 2: requesters 3 and 0 alternate across the wrap.
    ptrSeq[0] = 4'b1000;
    ptrSeq[1] = 4'b0001;
    ptrSeq[2] = 4'b1000;
    setOperand(0, 16'h7FFF, 16'h0003);
    setOperand(3, 16'hFFFF, 16'hFFFF);
    applyStimulus(4'b1001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("wrap_grant_%0d", k), {28'd0, bus.req_ready}, {28'd0, ptrSeq[k]});
      tick();
    end
    applyStimulus('0, 1'b1);
    waitDrain("wrap");

    // Asynchronous reset with both stages full.
    setOperand(0, 16'h1234, 16'h5678);
    applyStimulus(4'b0001, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("full_ready", {28'd0, bus.req_ready}, 0);
    checkOutput("full_busy", {31'd0, bus.busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_ready", {28'd0, bus.req_ready}, 0);
    checkOutput("async_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    checkOutput("async_rsp_p", bus.rsp_p, 0);
    checkOutput("async_rsp_id", {30'd0, bus.rsp_id}, 0);
    checkOutput("async_busy", {31'd0, bus.busy}, 0);
    tick();
    tick();
    applyStimulus('0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset_quiet_%0d", k), {31'd0, bus.rsp_valid}, 0);
    end
    tick();

    // Random regression against the scoreboard.
    base = rspCount;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        setOperand(i,
                   ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom),
                   ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom));
      end
      applyStimulus(4'($urandom), $urandom_range(0, 3) != 0);
      tick();
    end
    applyStimulus('0, 1'b1);
    waitDrain("rand");
    checkOutput("rand_progress", {31'd0, (rspCount - base) > 1000}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qlm_share_arb.md
# qlm_share_arb

Round-robin arbiter and two-stage pipeline controller that shares one `QLM_w4q3` approximate 16x16 multiplier among `NREQ` requesters. Each requester presents operands over a valid/ready handshake. The block registers the granted operands into the multiplier, registers the product, and returns it on a single response channel tagged with the requester index. It sits between multiple datapath clients and the single multiplier instance, replacing the free-running register wrapper when the multiplier must be time-shared with backpressure.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `IDW`, default 2: width of the requester index; must equal clog2(`NREQ`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: bit i set means requester i presents operands.
- `req_ready` out `NREQ`: one-hot or zero; bit i means requester i is accepted this cycle.
- `req_x` in `NREQ`*16: operand X for requester i in bits [16i+15:16i].
- `req_y` in `NREQ`*16: operand Y for requester i, same packing.
- `rsp_valid` out 1: response holds a product.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `IDW`: index of the requester that issued this product.
- `rsp_p` out 32: `QLM_w4q3` product of the accepted X and Y.
- `busy` out 1: set when either pipeline stage holds a valid entry.

## Operation
- Stage S1 holds registers `s1_v`, `s1_x[16]`, `s1_y[16]` and `s1_id`. `QLM_w4q3` is instantiated once, combinationally, with inputs `s1_x` and `s1_y`.
- Stage S2 holds registers `rsp_valid`, `rsp_p` and `rsp_id`, loaded from the multiplier output and `s1_id`.
- Stall rules:
  - `s2_adv = !rsp_valid | rsp_ready`
  - `s1_adv = !s1_v | s2_adv`
- Grant:
  - When `s1_adv` is 1, grant the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo `NREQ`.
  - `req_ready` equals the one-hot grant. It is all-zero when `s1_adv` is 0 or no request is present.
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `s1_v`.
- On a handshake (`req_valid[i] & req_ready[i]`):
  - S1 loads the operands of requester i, sets `s1_id=i` and `s1_v=1`.
  - `rr_ptr` becomes (i+1) mod `NREQ`.
  - With no handshake, `rr_ptr` holds.
- When `s1_adv` is 1 with no grant, `s1_v` is cleared.
- When `s2_adv` is 1:
  - `rsp_valid` loads `s1_v`.
  - `rsp_p` and `rsp_id` load only if `s1_v` is 1; otherwise they hold.
- While `rsp_valid` is 1 and `rsp_ready` is 0, `rsp_valid`, `rsp_p` and `rsp_id` are held stable.
- Requests are never dropped or reordered. Responses leave in grant order.
- A requester may hold `req_valid` indefinitely. Operands are sampled only on the handshake cycle.
- Product arithmetic is defined entirely by `QLM_w4q3`. The block does no rounding, truncation or extension; all 32 product bits pass through.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `s1_v`=0, `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `rr_ptr`=0, `busy`=0.
  - `req_ready` is forced to 0 while reset is asserted.
  - S1 operand registers clear to 0.
- Reset mid-operation discards in-flight entries immediately. No response is emitted for them.
- Latency: a handshake at edge N gives `rsp_valid`=1 after edge N+1, with the product valid in the same cycle.
- Throughput: one product per cycle while `rsp_ready` is held at 1. Back-to-back grants are allowed from the same requester or from different ones.
- Full condition: `rsp_valid`=1, `rsp_ready`=0 and `s1_v`=1 gives `req_ready`=0.
- Simultaneous events:
  - A response drain and a new grant happen in the same cycle; this does not create a bubble.
  - If all `req_valid` bits are set, grants rotate 0,1,2,3,0,... starting from reset.
- Wrap-around: when `rr_ptr` = `NREQ`-1 and that requester is idle, the search wraps to 0.
- `busy` is `s1_v | rsp_valid`, registered-derived and glitch-free.

## Test plan
- Single request: after reset, requester 2 sends x=0x0040, y=0x0020 with `rsp_ready`=1. Expect `req_ready`=4'b0100 in the same cycle; two edges later `rsp_valid`=1, `rsp_id`=2, and `rsp_p` equal to a standalone `QLM_w4q3` fed the same operands. Expect `busy` to fall one cycle after the drain.
- Round-robin fairness: all four requesters hold valid with distinct operands (x=0x1111·(i+1), y=0x0101) for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and 8 responses with matching `rsp_id` in order.
- Backpressure: stream from requester 1 while `rsp_ready`=0 for 5 cycles. Expect exactly 2 accepts, then `req_ready`=0; `rsp_p` and `rsp_id` stay stable; no loss and no duplicates after release.
- Pointer skip and wrap: requesters 3 and 0 hold valid with `rr_ptr`=2. Expect grant order 3, then 0, then 3.
- Asynchronous reset mid-flight: assert `rst_n`=0 between edges with both stages full. Expect all outputs to read 0 immediately, and no response after release until a new handshake.
- Random regression: 10k cycles of random `req_valid`, `rsp_ready` and operands. Scoreboard the order, ids and products against the golden `QLM_w4q3` model. Assert that `req_ready` is at most one-hot.
